// File: rtl/video_mode_pkg.sv
// video_mode_pkg: shared types for the video-mode reconfiguration sequencer.
//   vm_state_t : sequencer states
//   cnt_w()    : width of a saturating counter that must reach the value p
package video_mode_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        RUN,
        DEBOUNCE,
        START,
        WAIT_RDY,
        FAIL
    } vm_state_t;

    // Never returns 0 so a zero-valued parameter still yields a legal vector.
    function automatic int cnt_w(input int p);
        return (p < 1) ? 1 : $clog2(p + 1);
    endfunction

endpackage

// File: rtl/vm_counter.sv
// vm_counter: saturating up-counter with synchronous clear and enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : count up by one, holding at MAX-1
//   tc       : count equals MAX-1 (the MAX-th counted cycle is in progress)
module vm_counter
    import video_mode_pkg::*;
#(
    parameter int MAX = 16,
    parameter int W   = cnt_w(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: debounces video-mode requests, strobes the MMCM DRP
// engine, and qualifies MMCM lock (timeout, retries, settle) before
// releasing locked_out to the timing generator.
//   clk, rst    : clock, synchronous active-high reset
//   video_mode  : requested mode code
//   rst_mmcm    : external MMCM reset request
//   locked_in   : MMCM lock (already synchronised)
//   srdy        : DRP engine done pulse
//   sen         : one-cycle reconfiguration strobe
//   mode_out    : mode being / last applied (valid with sen)
//   locked_out  : qualified lock, high only in RUN
//   busy        : high outside RUN and FAIL
//   timeout_err : sticky failure flag, cleared only by rst
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int MODE_W         = 3,
    parameter int RESET_MODE     = 0,
    parameter int STABLE_CYCLES  = 16,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] video_mode,
    input  logic              rst_mmcm,
    input  logic              locked_in,
    input  logic              srdy,
    output logic              sen,
    output logic [MODE_W-1:0] mode_out,
    output logic              locked_out,
    output logic              busy,
    output logic              timeout_err
);

    localparam int            RW         = cnt_w(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    vm_state_t         state, state_nxt, retry_st;
    logic [MODE_W-1:0] req_q, req_d;
    logic [RW-1:0]     retry_q;
    logic              req_chg, mmcm_rst_hit;
    logic              deb_tc, set_tc, to_tc;
    logic              to_clr, retry_inc, retry_clr, load_mode;

    assign req_chg      = (req_q != req_d);
    assign mmcm_rst_hit = rst_mmcm && (state != FAIL);

    vm_counter #(.MAX(STABLE_CYCLES)) u_deb (
        .clk (clk), .rst (rst),
        .clr (state != DEBOUNCE || req_chg),
        .en  (1'b1),
        .tc  (deb_tc)
    );

    vm_counter #(.MAX(SETTLE_CYCLES)) u_settle (
        .clk (clk), .rst (rst),
        .clr (state != SETTLE),
        .en  (locked_in),
        .tc  (set_tc)
    );

    vm_counter #(.MAX(TIMEOUT_CYCLES)) u_timeout (
        .clk (clk), .rst (rst),
        .clr (to_clr),
        .en  (state == WAIT_LOCK || state == WAIT_RDY),
        .tc  (to_tc)
    );

    always_comb begin
        state_nxt = state;
        load_mode = 1'b0;
        retry_st  = (retry_q < RETRY_LAST) ? START : FAIL;
        if (mmcm_rst_hit) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (locked_in) state_nxt = SETTLE;
                           else if (to_tc) state_nxt = retry_st;
                SETTLE:    if (!locked_in) state_nxt = WAIT_LOCK;
                           else if (set_tc) state_nxt = RUN;
                RUN:       if (req_q != mode_out) state_nxt = DEBOUNCE;
                           else if (!locked_in) state_nxt = WAIT_LOCK;
                DEBOUNCE: begin
                    if (req_q == mode_out)
                        state_nxt = locked_in ? RUN : WAIT_LOCK;
                    else if (deb_tc && !req_chg) begin
                        state_nxt = START;
                        load_mode = 1'b1;
                    end
                end
                START:     state_nxt = WAIT_RDY;
                WAIT_RDY:  if (srdy) state_nxt = WAIT_LOCK;
                           else if (to_tc) state_nxt = retry_st;
                FAIL:      if (req_q != mode_out) state_nxt = DEBOUNCE;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Lock flapping between WAIT_LOCK and SETTLE must not extend the
    // per-attempt timeout, so only those two transitions keep the count.
    always_comb begin
        to_clr = mmcm_rst_hit;
        if (state_nxt != state &&
            !(state == WAIT_LOCK && state_nxt == SETTLE) &&
            !(state == SETTLE && state_nxt == WAIT_LOCK))
            to_clr = 1'b1;
    end

    assign retry_inc = (state == WAIT_LOCK || state == WAIT_RDY) && state_nxt == START;
    assign retry_clr = (state_nxt != state) && (state_nxt == RUN || state_nxt == DEBOUNCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            req_q       <= MODE_W'(RESET_MODE);
            req_d       <= MODE_W'(RESET_MODE);
            mode_out    <= MODE_W'(RESET_MODE);
            retry_q     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= video_mode;
            req_d <= req_q;
            // Latched only on DEBOUNCE->START so retries re-strobe the same mode.
            if (load_mode)
                mode_out <= req_q;
            if (retry_clr)
                retry_q <= '0;
            else if (retry_inc)
                retry_q <= retry_q + RW'(1);
            if (state_nxt == FAIL)
                timeout_err <= 1'b1;
        end
    end

    assign sen        = (state == START);
    assign locked_out = (state == RUN);
    assign busy       = (state != RUN) && (state != FAIL);

endmodule

// File: tb/tb_video_mode_ctrl.sv
module tb_video_mode_ctrl;

    localparam int STABLE = 4;
    localparam int SETTLE = 4;
    localparam int TMO    = 8;
    localparam int RETRY  = 2;

    logic       clk = 1'b0;
    logic       rst, rst_mmcm, locked_in, srdy;
    logic [2:0] video_mode;
    logic       sen, locked_out, busy, timeout_err;
    logic [2:0] mode_out;

    int n_checks = 0;
    int n_pass   = 0;
    int sen_cnt  = 0;
    int dbl_cnt  = 0;
    logic sen_prev = 1'b0;

    always #5 clk = ~clk;

    video_mode_ctrl #(
        .MODE_W(3), .RESET_MODE(0), .STABLE_CYCLES(STABLE),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(RETRY)
    ) dut (
        .clk(clk), .rst(rst), .video_mode(video_mode), .rst_mmcm(rst_mmcm),
        .locked_in(locked_in), .srdy(srdy), .sen(sen), .mode_out(mode_out),
        .locked_out(locked_out), .busy(busy), .timeout_err(timeout_err)
    );

    // Strobe bookkeeping: total pulses and back-to-back pulses.
    always @(posedge clk) begin
        if (rst) begin
            sen_prev <= 1'b0;
        end else begin
            if (sen) sen_cnt <= sen_cnt + 1;
            if (sen && sen_prev) dbl_cnt <= dbl_cnt + 1;
            sen_prev <= sen;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps until sen is seen; -1 if the bound expires.
    task automatic wait_sen(input int max, output int lat);
        lat = 0;
        do begin step(1); lat++; end while (!sen && lat < max);
        if (!sen) lat = -1;
    endtask

    task automatic wait_lock(input int max, output int lat);
        lat = 0;
        do begin step(1); lat++; end while (!locked_out && lat < max);
        if (!locked_out) lat = -1;
    endtask

    function automatic logic [2:0] other_mode(input logic [2:0] m);
        return 3'((int'(m) + 1 + $urandom_range(0, 6)) % 8);
    endfunction

    // Model: mode change -> strobe STABLE+2 cycles later; srdy -> lock
    // qualified SETTLE+1 cycles after the srdy cycle; each timeout costs TMO+1.
    initial begin
        logic [2:0] exp_mode, nm;
        int exp_sen, lat, base, d, g;
        exp_mode = 3'd0;
        exp_sen  = 0;

        rst = 1'b1; rst_mmcm = 1'b0; locked_in = 1'b1; srdy = 1'b0; video_mode = 3'd0;
        step(3);
        chk("rst_sen", sen, 0);
        chk("rst_locked_out", locked_out, 0);
        chk("rst_busy", busy, 1);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_mode_out", mode_out, 0);

        rst = 1'b0;
        step(SETTLE);
        chk("boot_not_yet_locked", locked_out, 0);
        step(1);
        chk("boot_locked", locked_out, 1);
        chk("boot_busy", busy, 0);
        chk("boot_no_sen", sen_cnt, 0);

        // Directed mode change 0 -> 5.
        exp_mode = 3'd5; video_mode = exp_mode;
        wait_sen(20, lat); exp_sen++;
        chk("chg_sen_lat", lat, STABLE + 2);
        chk("chg_mode_out", mode_out, exp_mode);
        step(1);
        chk("chg_sen_one_cycle", sen, 0);
        srdy = 1'b1; step(1); srdy = 1'b0;
        wait_lock(20, lat);
        chk("chg_relock", lat, SETTLE + 1);

        // Glitch 5 -> 2 -> 5 shorter than the debounce window.
        base = sen_cnt;
        video_mode = 3'd2; step(2); video_mode = exp_mode; step(8);
        chk("glitch_no_sen", sen_cnt - base, 0);
        chk("glitch_locked", locked_out, 1);
        chk("glitch_mode_out", mode_out, exp_mode);

        // Randomized changes, optional glitches, random srdy delay.
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                g = $urandom_range(1, 3);
                base = sen_cnt;
                video_mode = other_mode(exp_mode); step(g);
                video_mode = exp_mode; step(8);
                chk("rnd_glitch_no_sen", sen_cnt - base, 0);
                chk("rnd_glitch_locked", locked_out, 1);
            end
            nm = other_mode(exp_mode);
            exp_mode = nm; video_mode = nm;
            wait_sen(20, lat); exp_sen++;
            chk("rnd_sen_lat", lat, STABLE + 2);
            chk("rnd_mode_out", mode_out, nm);
            d = $urandom_range(0, 5);
            step(1 + d);
            chk("rnd_busy_wait_rdy", busy, 1);
            srdy = 1'b1; step(1); srdy = 1'b0;
            wait_lock(20, lat);
            chk("rnd_relock", lat, SETTLE + 1);
        end

        // srdy while in RUN is ignored.
        srdy = 1'b1; step(1); srdy = 1'b0; step(1);
        chk("srdy_ignored", locked_out, 1);

        // Lock loss and recovery.
        locked_in = 1'b0; step(1);
        chk("lockloss_locked_out", locked_out, 0);
        locked_in = 1'b1;
        wait_lock(20, lat);
        chk("lockloss_relock", lat, SETTLE + 1);

        // rst_mmcm pulse in RUN.
        base = sen_cnt;
        rst_mmcm = 1'b1; step(1); rst_mmcm = 1'b0;
        chk("rstmmcm_locked_out", locked_out, 0);
        wait_lock(20, lat);
        chk("rstmmcm_relock", lat, SETTLE + 1);
        chk("rstmmcm_no_sen", sen_cnt - base, 0);

        // Timeout: srdy never comes -> 1 + RETRY strobes, then FAIL.
        nm = other_mode(exp_mode); exp_mode = nm; video_mode = nm;
        base = sen_cnt;
        wait_sen(20, lat);
        chk("tmo_first_sen", lat, STABLE + 2);
        for (int r = 0; r < RETRY; r++) begin
            wait_sen(30, lat);
            chk("tmo_retry_gap", lat, TMO + 1);
        end
        exp_sen += RETRY + 1;
        step(TMO);
        chk("tmo_err_not_yet", timeout_err, 0);
        chk("tmo_busy_not_yet", busy, 1);
        step(1);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_locked_out", locked_out, 0);
        chk("tmo_busy_fail", busy, 0);
        step(12);
        chk("tmo_sen_count", sen_cnt - base, RETRY + 1);
        chk("tmo_mode_out", mode_out, exp_mode);
        rst_mmcm = 1'b1; step(1); rst_mmcm = 1'b0; step(2);
        chk("fail_ignores_rstmmcm", busy, 0);

        // New mode out of FAIL; error flag stays sticky.
        nm = other_mode(exp_mode); exp_mode = nm; video_mode = nm;
        wait_sen(20, lat); exp_sen++;
        chk("fail_exit_sen_lat", lat, STABLE + 2);
        chk("fail_exit_mode_out", mode_out, nm);
        chk("fail_exit_err_sticky", timeout_err, 1);
        step(2);
        srdy = 1'b1; step(1); srdy = 1'b0;
        wait_lock(20, lat);
        chk("fail_exit_relock", lat, SETTLE + 1);
        chk("fail_exit_err_still", timeout_err, 1);

        // Mode change while waiting for lock: acted on once RUN is reached.
        locked_in = 1'b0; step(1);
        chk("wl_locked_out", locked_out, 0);
        base = sen_cnt;
        nm = other_mode(exp_mode); exp_mode = nm; video_mode = nm; locked_in = 1'b1;
        wait_sen(30, lat); exp_sen++;
        chk("wl_sen_lat", lat, SETTLE + STABLE + 2);
        chk("wl_mode_out", mode_out, nm);
        step(1);
        srdy = 1'b1; step(1); srdy = 1'b0;
        wait_lock(20, lat);
        chk("wl_relock", lat, SETTLE + 1);
        step(10);
        chk("wl_one_sen", sen_cnt - base, 1);

        chk("sen_total", sen_cnt, exp_sen);
        chk("sen_never_doubled", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Parametrised video-mode reconfiguration sequencer between the mode-select logic and the pixel-clock MMCM DRP engine. It detects a change of requested video mode and debounces it. It then issues a one-cycle reconfiguration strobe and waits for the DRP engine to finish. It qualifies MMCM lock with a timeout, bounded retries and a settle period before releasing `locked_out` to the video timing generator.

## Interface
Parameters:
- `MODE_W`, 3, width of the video mode code
- `RESET_MODE`, 0, mode the MMCM powers up in; value of `mode_out` after reset
- `STABLE_CYCLES`, 16, cycles `video_mode` must stay constant before a change is accepted (≥1)
- `SETTLE_CYCLES`, 256, cycles `locked_in` must stay high before `locked_out` rises (≥1)
- `TIMEOUT_CYCLES`, 65536, maximum cycles in WAIT_RDY or WAIT_LOCK per attempt
- `MAX_RETRY`, 3, re-strobes after a timeout before declaring failure

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `video_mode` in MODE_W: requested mode, synchronous to `clk`
- `rst_mmcm` in 1: external MMCM reset request
- `locked_in` in 1: MMCM lock, already synchronised to `clk`
- `srdy` in 1: DRP engine done pulse
- `sen` out 1: one-cycle reconfiguration start strobe
- `mode_out` out MODE_W: mode being or last applied; valid while `sen` is high
- `locked_out` out 1: qualified lock
- `busy` out 1: high in every state except RUN and FAIL
- `timeout_err` out 1: sticky failure flag

## Operation
Register `video_mode` once into `req_q`. All comparisons use `req_q`.

States and transitions:
- **WAIT_LOCK**: entered on reset.
  - `locked_in`=1 → SETTLE.
  - Timeout → retry path.
- **SETTLE**: counts `SETTLE_CYCLES` consecutive cycles of `locked_in`=1.
  - `locked_in`=0 → WAIT_LOCK, settle counter cleared, timeout counter not cleared.
  - Count done → RUN.
- **RUN**: `locked_out`=1.
  - `req_q`≠`mode_out` → DEBOUNCE.
  - `locked_in`=0 → WAIT_LOCK, timeout counter cleared.
- **DEBOUNCE**: counts cycles with `req_q` unchanged.
  - Any change of `req_q` restarts the count.
  - `req_q`==`mode_out` → RUN if `locked_in`=1, else WAIT_LOCK.
  - `STABLE_CYCLES` reached → START.
- **START**: `mode_out`←`req_q`, `sen`=1 for exactly this cycle → WAIT_RDY.
- **WAIT_RDY**: `srdy`=1 → WAIT_LOCK, timeout counter cleared. Timeout → retry path.
- **FAIL**: `locked_out`=0, `timeout_err`=1.
  - Leaves only when `req_q`≠`mode_out` (→ DEBOUNCE) or on `rst`.
  - `timeout_err` clears only on `rst`.

Retry path:
- Retry counter < `MAX_RETRY`: increment it → START, re-strobing the same `mode_out`.
- Otherwise → FAIL.
- The retry counter clears on entering RUN and on entering DEBOUNCE.

Boundary conditions:
- `rst_mmcm`=1 in any state except FAIL → WAIT_LOCK next cycle with timeout counter cleared. No `sen` is issued.
- `rst_mmcm`=1 in WAIT_RDY abandons that attempt.
- A mode change in WAIT_RDY, WAIT_LOCK or SETTLE is not acted on until RUN, because RUN re-compares. No strobe is lost or doubled.
- `srdy` outside WAIT_RDY is ignored.
- `locked_out` is 1 only in RUN.

## Timing
- Reset values: state WAIT_LOCK, `sen`=0, `locked_out`=0, `busy`=1, `timeout_err`=0, `mode_out`=RESET_MODE, all counters 0.
- Mode change latency: `video_mode` changes at cycle N, `req_q` at N+1, DEBOUNCE entered at N+2, `sen` at N+2+`STABLE_CYCLES`.
- Lock loss: `locked_in` falls at cycle N → `locked_out`=0 from N+1. This is registered, not asynchronous.
- Lock release: `locked_out` rises on the cycle after the `SETTLE_CYCLES`-th consecutive high sample.
- Timeout fires on the cycle the counter reaches `TIMEOUT_CYCLES-1`.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.
- `sen` is never high on two consecutive cycles.

## Structure
- Package `video_mode_pkg`: state enum `vm_state_t` (WAIT_LOCK, SETTLE, RUN, DEBOUNCE, START, WAIT_RDY, FAIL) and a `cnt_w` width helper function.
- One sub-module, `vm_counter`: saturating up-counter with clear, enable and a terminal-count output. It is instantiated for debounce, settle and timeout.
- The retry counter is inline.

## Test plan
- Reset with `locked_in` high, `SETTLE_CYCLES`=4 → `locked_out` rises on the 5th cycle after reset release; no `sen` is issued.
- In RUN, `video_mode` 0→5 held, `STABLE_CYCLES`=4 → one `sen` pulse 6 cycles later with `mode_out`=5. After `srdy` and 4 lock cycles, RUN is re-entered.
- Glitch `video_mode` 0→2→0 within 3 cycles → no `sen`, `locked_out` stays 1.
- `TIMEOUT_CYCLES`=8, `MAX_RETRY`=2, `srdy` never asserted → 3 `sen` pulses 9 cycles apart, then FAIL with `timeout_err`=1 and `locked_out`=0. A new mode restarts the sequence with `timeout_err` still 1.
- `rst_mmcm` pulse in RUN → `locked_out`=0 next cycle, no `sen`; RUN is re-entered after settle.
- Mode change during WAIT_LOCK → after RUN is reached, DEBOUNCE is entered and exactly one new `sen` is issued.
